beat_timer: RTL

- Timing generator that drives the hardwired controller. It produces the beat signals W[3:1] and the phase strobes T1/T2/T3.
- It consumes the controller's SHORT, LONG and STOP outputs to decide the next beat, or to halt the machine.
- It sits between the board clock, the start button QD and the single-step switch DP on one side, and the controller/datapath on the other.
- The controller advances its own state on the falling edge of T3. W is therefore only allowed to change at that boundary.

---
 rtl/beat_pkg.sv | 25 ++
 rtl/beat_timer_edge_sync.sv | 43 ++++
 rtl/beat_timer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/beat_pkg.sv
// -----------------------------------------------------------------------------
// beat_pkg
// Shared definitions for the beat timer that drives the hardwired controller.
//   - beat_state_t : phase FSM encoding (HALT, PH1, PH2, PH3)
//   - W1/W2/W3     : one-hot beat codes presented on W[3:1]
//   - SYNC_STAGES_DEF : default depth of the QD synchronizer
//   - PHASE_CNT_W  : width of the per-phase down-counter
// -----------------------------------------------------------------------------
package beat_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        PH3  = 2'd3
    } beat_state_t;

    localparam logic [2:0] W1 = 3'b001;
    localparam logic [2:0] W2 = 3'b010;
    localparam logic [2:0] W3 = 3'b100;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int PHASE_CNT_W     = 4;

endpackage

// File: rtl/beat_timer_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous, active-high level (the QD pushbutton) into the CLK
// domain through a SYNC_STAGES-deep flip-flop chain and produces a one-cycle
// pulse on each synchronized rising edge.
//
// Ports:
//   CLK      in  1  system clock, rising edge
//   CLR      in  1  asynchronous active-low reset; clears chain and detector
//   async_in in  1  asynchronous level to be synchronized
//   rise     out 1  high for exactly one CLK after a synchronized 0->1 edge
// -----------------------------------------------------------------------------
module edge_sync
    import beat_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic CLK,
    input  logic CLR,
    input  logic async_in,
    output logic rise
);

    // sync_q[0] is the metastability-catching stage; the last stage is the
    // first one safe to use in logic.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A level that stays high produces only one pulse, so a held button
    // cannot restart the machine repeatedly.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/beat_timer.sv
// -----------------------------------------------------------------------------
// beat_timer
// Timing generator for the hardwired controller. Each beat consists of three
// phases; each phase strobe (T1, T2, T3) is high for PHASE_CYCLES clocks. At
// the last clock of T3 the controller's SHORT/LONG/STOP and the DP switch are
// sampled, the next beat is loaded into W and the block either continues with
// the next beat or halts until a fresh QD press.
//
// Ports:
//   CLK       in  1  system clock, rising edge
//   CLR       in  1  asynchronous active-low reset
//   QD        in  1  start pushbutton, asynchronous, active-high
//   DP        in  1  single-step mode: halt after every beat
//   SHORT     in  1  controller: instruction ends after W1
//   LONG      in  1  controller: instruction needs W3
//   STOP      in  1  controller: halt when the current beat ends
//   W         out 3  one-hot beat W[1]/W[2]/W[3]
//   T1,T2,T3  out 1  phase strobes; T3 falling edge ends the beat
//   RUN       out 1  high while beats are being issued
//   BEAT_END  out 1  one-CLK pulse on the final CLK of T3
//
// Parameters:
//   PHASE_CYCLES  clocks per phase strobe, 1..15
//   SYNC_STAGES   QD synchronizer depth, 2..4
// -----------------------------------------------------------------------------
module beat_timer
    import beat_pkg::*;
#(
    parameter int PHASE_CYCLES = 1,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       QD,
    input  logic       DP,
    input  logic       SHORT,
    input  logic       LONG,
    input  logic       STOP,
    output logic [2:0] W,
    output logic       T1,
    output logic       T2,
    output logic       T3,
    output logic       RUN,
    output logic       BEAT_END
);

    // Counter reload value: a phase lasts PH_LOAD+1 clocks.
    localparam logic [PHASE_CNT_W-1:0] PH_LOAD = PHASE_CNT_W'(PHASE_CYCLES - 1);

    beat_state_t            state_q;
    beat_state_t            state_d;
    logic [PHASE_CNT_W-1:0] cnt_q;
    logic [PHASE_CNT_W-1:0] cnt_d;
    logic [2:0]             w_q;
    logic [2:0]             w_d;
    logic                   qd_rise;
    logic                   phase_done;
    logic                   beat_last;

    // Next-beat rule. Any code that is not W1 or W2 (W3, or an illegal value)
    // goes to W1, so W always recovers to a legal one-hot value.
    function automatic logic [2:0] next_beat(input logic [2:0] cur,
                                             input logic       short_i,
                                             input logic       long_i);
        logic [2:0] nxt;
        case (cur)
            W1:      nxt = short_i ? W1 : W2;  // SHORT wins over LONG in W1
            W2:      nxt = long_i  ? W3 : W1;
            default: nxt = W1;
        endcase
        return nxt;
    endfunction

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_qd_sync (
        .CLK      (CLK),
        .CLR      (CLR),
        .async_in (QD),
        .rise     (qd_rise)
    );

    assign phase_done = (cnt_q == '0);
    assign beat_last  = (state_q == PH3) && phase_done;

    // ---- state register: FSM state, phase counter and current beat ----
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= HALT;
            cnt_q   <= '0;
            w_q     <= W1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            HALT: begin
                // QD edges are only acted upon here; edges arriving while
                // running are dropped, not queued.
                if (qd_rise) begin
                    state_d = PH1;
                end
            end
            PH1: begin
                if (phase_done) begin
                    state_d = PH2;
                end
            end
            PH2: begin
                if (phase_done) begin
                    state_d = PH3;
                end
            end
            PH3: begin
                if (phase_done) begin
                    state_d = (STOP || DP) ? HALT : PH1;
                end
            end
            default: state_d = HALT;
        endcase

        // Reload on every phase change (PH3->PH1 included), count down
        // inside a phase, and park at zero while halted.
        if (state_d == HALT) begin
            cnt_d = '0;
        end else if (state_d != state_q) begin
            cnt_d = PH_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        // W advances even when halting, so a restart resumes at the right
        // beat. It changes on the same edge that ends T3.
        w_d = beat_last ? next_beat(w_q, SHORT, LONG) : w_q;
    end

    // ---- output decode ----
    always_comb begin
        T1       = 1'b0;
        T2       = 1'b0;
        T3       = 1'b0;
        RUN      = 1'b0;
        BEAT_END = 1'b0;
        case (state_q)
            PH1: begin
                T1  = 1'b1;
                RUN = 1'b1;
            end
            PH2: begin
                T2  = 1'b1;
                RUN = 1'b1;
            end
            PH3: begin
                T3       = 1'b1;
                RUN      = 1'b1;
                BEAT_END = phase_done;
            end
            default: begin
                T1 = 1'b0;
            end
        endcase
    end

    assign W = w_q;

endmodule
